// File: rtl/sram_1rw1r_sync_model.sv
`default_nettype none
// sram_1rw1r_sync_model: single-clock 1RW+1R SRAM model with lane-masked writes,
// 1/2-cycle read latency, optional write-to-read forwarding and a post-reset clear sweep.
module sram_1rw1r_sync_model #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int NUM_WMASKS     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int FORWARD        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk0,
  input  logic                  rst0,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid,
  output logic                  collision1
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int LANE      = DATA_WIDTH / NUM_WMASKS;

  typedef enum logic [1:0] {ST_RESET = 2'd0, ST_CLEAR = 2'd1, ST_READY = 2'd2} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clear_addr;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic                  wr_en, rd0_en, rd1_en, collide;
  logic [DATA_WIDTH-1:0] rd1_word;
  logic                  s1_v0, s1_v1, s1_col;
  logic [DATA_WIDTH-1:0] s1_d0, s1_d1;

  always_ff @(posedge clk0) begin
    if (rst0) begin
      state      <= ST_RESET;
      clear_addr <= '0;
    end else begin
      state      <= state_next;
      clear_addr <= (state == ST_CLEAR) ? clear_addr + ADDR_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RESET: state_next = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      ST_CLEAR: if (clear_addr == {ADDR_WIDTH{1'b1}}) state_next = ST_READY;
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_RESET;
    endcase
  end

  assign ready   = (state == ST_READY);
  assign wr_en   = ready & ~rst0 & ~csb0 & ~web0;
  assign rd0_en  = ready & ~rst0 & ~csb0 & web0;
  assign rd1_en  = ready & ~rst0 & ~csb1;
  assign collide = wr_en & rd1_en & (addr0 == addr1);

  // The sweep word is skipped on a reset edge so a restarted sweep sees untouched memory.
  always_ff @(posedge clk0) begin
    if (state == ST_CLEAR && !rst0) begin
      mem[clear_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][i*LANE +: LANE] <= din0[i*LANE +: LANE];
      end
    end
  end

  always_comb begin
    rd1_word = mem[addr1];
    if (collide && FORWARD != 0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) rd1_word[i*LANE +: LANE] = din0[i*LANE +: LANE];
      end
    end
  end

  always_ff @(posedge clk0) begin
    if (rst0) begin
      s1_v0  <= 1'b0;
      s1_v1  <= 1'b0;
      s1_col <= 1'b0;
      s1_d0  <= '0;
      s1_d1  <= '0;
    end else begin
      s1_v0  <= rd0_en;
      s1_v1  <= rd1_en;
      s1_col <= collide;
      if (rd0_en) s1_d0 <= mem[addr0];
      if (rd1_en) s1_d1 <= rd1_word;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  s2_v0, s2_v1, s2_col;
      logic [DATA_WIDTH-1:0] s2_d0, s2_d1;

      always_ff @(posedge clk0) begin
        if (rst0) begin
          s2_v0  <= 1'b0;
          s2_v1  <= 1'b0;
          s2_col <= 1'b0;
          s2_d0  <= '0;
          s2_d1  <= '0;
        end else begin
          s2_v0  <= s1_v0;
          s2_v1  <= s1_v1;
          s2_col <= s1_col;
          if (s1_v0) s2_d0 <= s1_d0;
          if (s1_v1) s2_d1 <= s1_d1;
        end
      end

      assign dout0       = s2_d0;
      assign dout0_valid = s2_v0;
      assign dout1       = s2_d1;
      assign dout1_valid = s2_v1;
      assign collision1  = s2_col;
    end else begin : g_lat1
      assign dout0       = s1_d0;
      assign dout0_valid = s1_v0;
      assign dout1       = s1_d1;
      assign dout1_valid = s1_v1;
      assign collision1  = s1_col;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_1rw1r_sync_model.sv
`default_nettype none
// Instance A (latency 1, forwarding, clear sweep) and B (latency 2, old-data, no clear)
// share port stimulus; a per-edge behavioural model plus literal expectations judge both.
module tb_sram_1rw1r_sync_model;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0;
  logic        a_ready, a_v0, a_v1, a_col, b_ready, b_v0, b_v1, b_col;
  logic [31:0] a_d0, a_d1, b_d0, b_d1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always #5 clk = ~clk;

  sram_1rw1r_sync_model u_a (
    .clk0(clk), .rst0(rst_a), .ready(a_ready),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(a_d0), .dout0_valid(a_v0),
    .csb1(csb1), .addr1(addr1), .dout1(a_d1), .dout1_valid(a_v1), .collision1(a_col)
  );

  sram_1rw1r_sync_model #(.READ_LATENCY(2), .FORWARD(0), .CLEAR_ON_RESET(0)) u_b (
    .clk0(clk), .rst0(rst_b), .ready(b_ready),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(b_d0), .dout0_valid(b_v0),
    .csb1(csb1), .addr1(addr1), .dout1(b_d1), .dout1_valid(b_v1), .collision1(b_col)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          k;
    int          port;
    int          due;
    logic [31:0] d;
    logic        col;
  } ent_t;

  logic [31:0] mm [2][DEPTH];
  int          since [2];
  bit          m_rdy [2];
  logic        m_v0 [2], m_v1 [2], m_col [2];
  logic [31:0] m_d0 [2], m_d1 [2];
  ent_t        q[$];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  task automatic model_step(input int k, input logic rst);
    int          rl   = (k == 0) ? 1 : 2;
    bit          fwd  = (k == 0);
    bit          clr  = (k == 0);
    int          need = clr ? DEPTH + 1 : 1;
    logic [31:0] old1;
    logic        col;
    ent_t        e;
    if (rst) begin
      since[k] = 0; m_rdy[k] = 1'b0;
      m_v0[k] = 1'b0; m_v1[k] = 1'b0; m_col[k] = 1'b0;
      m_d0[k] = '0; m_d1[k] = '0;
      for (int i = q.size() - 1; i >= 0; i--) if (q[i].k == k) q.delete(i);
      return;
    end
    m_v0[k] = 1'b0; m_v1[k] = 1'b0; m_col[k] = 1'b0;
    if (!m_rdy[k]) begin
      since[k]++;
      if (since[k] == need) begin
        m_rdy[k] = 1'b1;
        if (clr) for (int a = 0; a < DEPTH; a++) mm[k][a] = '0;
      end
    end else begin
      if (!csb0 && web0) begin
        e.k = k; e.port = 0; e.due = cyc + rl - 1; e.d = mm[k][addr0]; e.col = 1'b0;
        q.push_back(e);
      end
      if (!csb1) begin
        col  = !csb0 && !web0 && (addr0 == addr1);
        old1 = mm[k][addr1];
        e.k = k; e.port = 1; e.due = cyc + rl - 1; e.col = col;
        e.d = (col && fwd) ? merge(old1, din0, wmask0) : old1;
        q.push_back(e);
      end
      if (!csb0 && !web0) mm[k][addr0] = merge(mm[k][addr0], din0, wmask0);
    end
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].k == k && q[i].due == cyc) begin
        if (q[i].port == 0) begin
          m_v0[k] = 1'b1; m_d0[k] = q[i].d;
        end else begin
          m_v1[k] = 1'b1; m_d1[k] = q[i].d; m_col[k] = q[i].col;
        end
        q.delete(i);
      end
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    model_step(0, rst_a);
    model_step(1, rst_b);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_a_ready", a_ready, m_rdy[0]); chk("m_b_ready", b_ready, m_rdy[1]);
      chk("m_a_v0", a_v0, m_v0[0]);        chk("m_b_v0", b_v0, m_v0[1]);
      chk("m_a_v1", a_v1, m_v1[0]);        chk("m_b_v1", b_v1, m_v1[1]);
      chk("m_a_col", a_col, m_col[0]);     chk("m_b_col", b_col, m_col[1]);
      chk("m_a_d0", a_d0, m_d0[0]);        chk("m_b_d0", b_d0, m_d0[1]);
      chk("m_a_d1", a_d1, m_d1[0]);        chk("m_b_d1", b_d1, m_d1[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; wmask0 = 4'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
  endtask

  task automatic rd0(input logic [7:0] a);
    csb0 = 1'b0; web0 = 1'b1; addr0 = a; wmask0 = 4'h0;
  endtask

  task automatic rd1(input logic [7:0] a);
    csb1 = 1'b0; addr1 = a;
  endtask

  task automatic wait_ready(input int k, input string name, input int want);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(k == 0 ? a_ready : b_ready) && n < 400);
    chk(name, n, want);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; idle();
    addr0 = '0; addr1 = '0; din0 = '0;
    tick(); chk_en = 1'b1; tick();
    chk("reset_ready_a", a_ready, 0);
    chk("reset_dout1_a", a_d1, 0);
    chk("reset_valid_b", b_v0, 0);
    rst_a = 1'b0; rst_b = 1'b0;

    // clear sweep latency, then a cleared word
    wait_ready(0, "t1_ready_latency", 257);
    rd1(8'h7F); tick(); idle();
    chk("t1_rd7f_valid", a_v1, 1);
    chk("t1_rd7f_data", a_d1, 32'h0);

    // lane-masked write over existing data
    wr(8'h10, 32'h11223344, 4'hF); tick();
    wr(8'h10, 32'hDEADBEEF, 4'b0101); tick(); idle();
    rd1(8'h10); tick(); idle();
    chk("t2_mask_a", a_d1, 32'h11AD33EF);
    tick();
    chk("t2_mask_b", b_d1, 32'h11AD33EF);

    // same-edge write/read collisions: full and partial mask
    wr(8'h20, 32'h0, 4'hF); tick();
    wr(8'h20, 32'hCAFEF00D, 4'hF); rd1(8'h20); tick(); idle();
    chk("t3_col_a", a_col, 1);
    chk("t3_fwd_a", a_d1, 32'hCAFEF00D);
    tick();
    chk("t3_col_b", b_col, 1);
    chk("t3_old_b", b_d1, 32'h0);
    wr(8'h20, 32'h12345678, 4'b0011); rd1(8'h20); tick(); idle();
    chk("t3_merge_a", a_d1, 32'hCAFE5678);
    tick();
    chk("t3_old_part_b", b_d1, 32'hCAFEF00D);
    rd1(8'h20); tick(); idle();
    chk("t3_after_a", a_d1, 32'hCAFE5678);
    chk("t3_after_col_a", a_col, 0);
    tick();
    chk("t3_after_b", b_d1, 32'hCAFE5678);

    // latency-2 pipelining on both ports
    for (int i = 1; i <= 3; i++) begin
      wr(i[7:0], 32'hA000_0000 | i, 4'hF); tick();
    end
    idle();
    rd1(8'd1); rd0(8'd3); tick();
    chk("t4_lat_b", b_v1, 0);
    rd1(8'd2); rd0(8'd2); tick();
    chk("t4_v1_b", b_v1, 1);
    chk("t4_d1_1_b", b_d1, 32'hA000_0001);
    chk("t4_d0_1_b", b_d0, 32'hA000_0003);
    rd1(8'd3); rd0(8'd1); tick(); idle();
    chk("t4_d1_2_b", b_d1, 32'hA000_0002);
    tick();
    chk("t4_d1_3_b", b_d1, 32'hA000_0003);
    chk("t4_d0_3_b", b_d0, 32'hA000_0001);
    tick();
    chk("t4_pulse_b", b_v1, 0);
    chk("t4_hold_b", b_d1, 32'hA000_0003);

    // reset of A while its sweep is at word 100; requests during the sweep
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    for (int i = 0; i < 101; i++) begin
      idle();
      if (i == 10) wr(8'h55, 32'h0BADF00D, 4'hF);
      if (i == 11) rd1(8'h55);
      tick();
      if (i == 11) chk("t5_no_valid_a", a_v1, 0);
    end
    idle();
    rst_a = 1'b1; tick(); rst_a = 1'b0;
    wait_ready(0, "t5_ready_latency", 257);
    rd1(8'h55); rd0(8'd1); tick(); idle();
    chk("t5_nowrite_a", a_d1, 32'h0);
    chk("t5_cleared_a", a_d0, 32'h0);
    tick();
    chk("t5_write_b", b_d1, 32'h0BADF00D);
    chk("t5_keep_b", b_d0, 32'hA000_0001);

    // contents preserved across reset without clear; dout0 holds when idle
    wr(8'h40, 32'hA5A55A5A, 4'hF); tick(); idle();
    rst_b = 1'b1; tick(); tick(); rst_b = 1'b0;
    wait_ready(1, "t6_ready_latency", 1);
    rd0(8'h40); tick(); idle(); tick();
    chk("t6_valid_b", b_v0, 1);
    chk("t6_keep_b", b_d0, 32'hA5A55A5A);
    tick(); tick(); tick();
    chk("t6_pulse_b", b_v0, 0);
    chk("t6_hold_b", b_d0, 32'hA5A55A5A);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
